alu_ctrl_gen: RTL and testbench

Registered ALU-control encoder for the decode stage. Accepts a 32-bit RV32I instruction and its PC over a valid/ready handshake and produces the 4-bit `alu_ctr` code consumed by the execute-stage ALU decoder, plus operand-select and illegal flags. A two-entry skid buffer gives full throughput under backpressure. It also keeps a saturating count of illegal instructions delivered downstream.

---
 rtl/alu_ctrl_gen.sv | 174 +++++++++++++++++
 tb/tb_alu_ctrl_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_gen.sv
// Decode-stage ALU-control encoder: RV32I instruction -> alu_ctr/src_imm/illegal,
// registered behind a two-entry skid buffer, with a saturating illegal counter.
module alu_ctrl_gen #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_alu_ctr,
    output logic             out_src_imm,
    output logic             out_illegal,
    output logic [XLEN-1:0]  out_pc,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic [3:0]      alu_ctr;
        logic            src_imm;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } entry_t;

    // State bits are {output reg valid, skid valid}, so both handshake
    // outputs fall straight out of the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    state_t     state, state_nxt;
    entry_t     out_q, skid_q, dec;
    logic       accept, drain;
    logic       load_in, load_skid_to_out, load_skid;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic       legal;

    assign op = in_instr[6:0];
    assign f3 = in_instr[14:12];
    assign f7 = in_instr[31:25];

    // Register/immediate fields play no part in the ALU control code.
    logic unused_fields;
    assign unused_fields = &{1'b0, in_instr[24:15], in_instr[11:7]};

    always_comb begin
        dec     = '0;
        dec.pc  = in_pc;
        legal   = 1'b1;
        unique case (op)
            OP_OP: begin
                dec.alu_ctr = {f7[5], f3};
                legal = (f7 == F7_ZERO) ||
                        ((f7 == F7_ALT) && (f3 == 3'b000 || f3 == 3'b101));
            end
            OP_IMM: begin
                dec.src_imm = 1'b1;
                dec.alu_ctr = {(f3 == 3'b101) ? f7[5] : 1'b0, f3};
                if (f3 == 3'b001)
                    legal = (f7 == F7_ZERO);
                else if (f3 == 3'b101)
                    legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
            end
            OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE, OP_JAL: begin
                dec.src_imm = 1'b1;
            end
            OP_JALR: begin
                dec.src_imm = 1'b1;
                legal = (f3 == 3'b000);
            end
            OP_BRANCH: begin
                unique case (f3[2:1])
                    2'b00:   dec.alu_ctr = 4'b1000;
                    2'b10:   dec.alu_ctr = 4'b0010;
                    2'b11:   dec.alu_ctr = 4'b0011;
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.alu_ctr = 4'b0000;
            dec.src_imm = 1'b0;
            dec.illegal = 1'b1;
        end
    end

    assign in_ready  = ~state[0];
    assign out_valid = state[1];
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_nxt        = state;
        load_in          = 1'b0;
        load_skid_to_out = 1'b0;
        load_skid        = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (accept) begin
                    state_nxt = ONE;
                    load_in   = 1'b1;
                end
                ONE: begin
                    if (accept && drain) begin
                        load_in = 1'b1;
                    end else if (drain) begin
                        state_nxt = EMPTY;
                    end else if (accept) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end
                end
                FULL: if (drain) begin
                    state_nxt        = ONE;
                    load_skid_to_out = 1'b1;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            if (load_in)
                out_q <= dec;
            else if (load_skid_to_out)
                out_q <= skid_q;
            if (load_skid)
                skid_q <= dec;
        end
    end

    // Drains count even in a flush cycle; flushed entries never do.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_cnt <= '0;
        else if (drain && out_q.illegal && (illegal_cnt != {CNT_W{1'b1}}))
            illegal_cnt <= illegal_cnt + 1'b1;
    end

    assign out_alu_ctr = out_q.alu_ctr;
    assign out_src_imm = out_q.src_imm;
    assign out_illegal = out_q.illegal;
    assign out_pc      = out_q.pc;

endmodule

// File: tb/tb_alu_ctrl_gen.sv
// Directed bench for alu_ctrl_gen: decode vectors, skid backpressure, flush,
// counter saturation and asynchronous reset, with hand-computed expectations.
module tb_alu_ctrl_gen;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_ready;
    logic [31:0] in_instr, in_pc, out_pc;
    logic        out_valid, out_src_imm, out_illegal;
    logic [3:0]  out_alu_ctr;
    logic [7:0]  illegal_cnt;
    int          checks = 0;
    int          errors = 0;

    alu_ctrl_gen #(.XLEN(32), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_ctr(out_alu_ctr),
        .out_src_imm(out_src_imm), .out_illegal(out_illegal), .out_pc(out_pc),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] alu, input logic imm,
                           input logic ill, input logic [31:0] pc);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_alu"}, out_alu_ctr, alu);
        check({tag, "_imm"}, out_src_imm, imm);
        check({tag, "_ill"}, out_illegal, ill);
        check({tag, "_pc"}, out_pc, pc);
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        #2;
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_alu", out_alu_ctr, 4'h0);
        check("rst_imm", out_src_imm, 1'b0);
        check("rst_ill", out_illegal, 1'b0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_cnt", illegal_cnt, 8'd0);
        #10 rst_n = 1'b1;

        // single sub, one-cycle latency
        offer(32'h40B50533, 32'h100);
        step();
        in_valid = 1'b0;
        chk_out("sub", 4'b1000, 1'b0, 1'b0, 32'h100);
        check("sub_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        step();
        check("sub_drained", out_valid, 1'b0);

        // back-to-back stream at full rate
        offer(32'h4032D293, 32'h104);
        step();
        chk_out("srai", 4'b1101, 1'b1, 1'b0, 32'h104);
        check("srai_ready", in_ready, 1'b1);
        offer(32'h0062E463, 32'h108);
        step();
        chk_out("bltu", 4'b0011, 1'b0, 1'b0, 32'h108);
        check("bltu_ready", in_ready, 1'b1);
        offer(32'h00A00093, 32'h10C);
        step();
        chk_out("addi", 4'b0000, 1'b1, 1'b0, 32'h10C);
        check("addi_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        step();
        check("stream_empty", out_valid, 1'b0);

        // backpressure: A, B accepted, C stalled
        out_ready = 1'b0;
        offer(32'h00A00093, 32'h200);
        step();
        check("bp_a_ready", in_ready, 1'b1);
        offer(32'h40B50533, 32'h204);
        step();
        check("bp_full_ready", in_ready, 1'b0);
        chk_out("bp_a", 4'b0000, 1'b1, 1'b0, 32'h200);
        offer(32'h4032D293, 32'h208);
        step();
        check("bp_stall_ready", in_ready, 1'b0);
        chk_out("bp_hold1", 4'b0000, 1'b1, 1'b0, 32'h200);
        step();
        chk_out("bp_hold2", 4'b0000, 1'b1, 1'b0, 32'h200);
        out_ready = 1'b1;
        step();
        chk_out("bp_b", 4'b1000, 1'b0, 1'b0, 32'h204);
        check("bp_reopen", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk_out("bp_c", 4'b1101, 1'b1, 1'b0, 32'h208);
        step();
        check("bp_empty", out_valid, 1'b0);

        // illegal instructions
        offer(32'h00000000, 32'h300);
        step();
        chk_out("ill_zero", 4'b0000, 1'b0, 1'b1, 32'h300);
        offer(32'h0200D013, 32'h304);
        step();
        chk_out("ill_srli", 4'b0000, 1'b0, 1'b1, 32'h304);
        in_valid = 1'b0;
        step();
        check("ill_cnt2", illegal_cnt, 8'd2);

        // flush while FULL with an offered instruction
        out_ready = 1'b0;
        offer(32'h00000000, 32'h400);
        step();
        step();
        check("fl_full", in_ready, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", out_valid, 1'b0);
        check("fl_ready", in_ready, 1'b1);
        check("fl_cnt", illegal_cnt, 8'd2);
        step();
        check("fl_stays_empty", out_valid, 1'b0);

        // a drain in the flush cycle still counts
        offer(32'h00000000, 32'h500);
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_drain_cnt", illegal_cnt, 8'd3);
        check("fl_drain_valid", out_valid, 1'b0);

        // 300 illegal drains: 3 + 251 = 254 after 252 cycles, then saturate
        offer(32'h00000000, 32'h600);
        for (int i = 0; i < 252; i++) step();
        check("sat_254", illegal_cnt, 8'd254);
        for (int i = 0; i < 48; i++) step();
        in_valid = 1'b0;
        step();
        check("sat_255", illegal_cnt, 8'd255);
        check("sat_empty", out_valid, 1'b0);

        // asynchronous reset while FULL
        out_ready = 1'b0;
        offer(32'h40B50533, 32'h700);
        step();
        step();
        in_valid = 1'b0;
        check("ar_full", in_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 1'b0);
        check("ar_cnt", illegal_cnt, 8'd0);
        check("ar_ready", in_ready, 1'b1);
        check("ar_pc", out_pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
